// File: rtl/sca_test_sequencer.sv
// Pattern sequencer for the sca_unlock harness: serial load, flip burst, settle, scan capture
// and deserialization of the DUT outputs into resp.
module sca_test_sequencer #(
    parameter int unsigned NUM_INS     = 8,
    parameter int unsigned NUM_OUTS    = 4,
    parameter int unsigned NUM_COPY    = 1,
    parameter int unsigned FLIP_PULSES = 16,
    parameter int unsigned CLK_DIV     = 2,
    parameter int unsigned SETTLE_CYC  = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [NUM_INS-1:0]           pattern_val,
    input  logic [NUM_INS-1:0]           pattern_flip,
    output logic                         busy,
    output logic                         done,
    output logic [NUM_OUTS*NUM_COPY-1:0] resp,
    output logic                         sca_clk,
    output logic                         sca_data,
    output logic                         flip_clk,
    output logic                         shift_out_enable,
    output logic                         shift_out_clk,
    input  logic                         shift_out_data
);

    localparam int unsigned WORD_W = 2 * NUM_INS;
    localparam int unsigned LEN    = NUM_OUTS * NUM_COPY;
    localparam int unsigned PERIOD = 2 * CLK_DIV;
    localparam int unsigned PH_W   = $clog2(PERIOD);
    localparam int unsigned MAX_A  = (WORD_W > FLIP_PULSES) ? WORD_W : FLIP_PULSES;
    localparam int unsigned MAX_B  = (MAX_A > LEN) ? MAX_A : LEN;
    localparam int unsigned MAX_C  = (MAX_B > SETTLE_CYC) ? MAX_B : SETTLE_CYC;
    localparam int unsigned BIT_W  = $clog2(MAX_C + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_FLIP, S_SETTLE, S_CAPTURE, S_SHIFT, S_DONE
    } state_t;

    state_t            state_q, state_d, next_st;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [BIT_W-1:0]  bit_q, bit_d, last_bit;
    logic [WORD_W-1:0] word_q, word_d, load_bits;
    logic [LEN-1:0]    shreg_q, shreg_d, resp_q, resp_d;
    logic              periodic, period_end, hi_d;
    logic busy_q, busy_d, done_q, done_d, sca_clk_q, sca_clk_d, sca_data_q, sca_data_d;
    logic flip_clk_q, flip_clk_d, so_en_q, so_en_d, so_clk_q, so_clk_d;

    // State register and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            phase_q    <= '0;
            bit_q      <= '0;
            word_q     <= '0;
            shreg_q    <= '0;
            resp_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sca_clk_q  <= 1'b0;
            sca_data_q <= 1'b0;
            flip_clk_q <= 1'b0;
            so_en_q    <= 1'b0;
            so_clk_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            bit_q      <= bit_d;
            word_q     <= word_d;
            shreg_q    <= shreg_d;
            resp_q     <= resp_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sca_clk_q  <= sca_clk_d;
            sca_data_q <= sca_data_d;
            flip_clk_q <= flip_clk_d;
            so_en_q    <= so_en_d;
            so_clk_q   <= so_clk_d;
        end
    end

    // Next state; outputs are derived from the next state so they register in step with it
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        bit_d      = bit_q;
        word_d     = word_q;
        shreg_d    = shreg_q;
        resp_d     = resp_q;
        next_st    = state_q;
        last_bit   = '0;
        periodic   = 1'b0;
        period_end = (phase_q == PH_W'(PERIOD - 1));

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    word_d  = {pattern_flip, pattern_val};
                end
            end
            S_LOAD: begin
                periodic = 1'b1;
                last_bit = BIT_W'(WORD_W - 1);
                next_st  = (FLIP_PULSES == 0) ? S_SETTLE : S_FLIP;
            end
            S_FLIP: begin
                periodic = 1'b1;
                last_bit = BIT_W'(FLIP_PULSES - 1);
                next_st  = S_SETTLE;
            end
            S_SETTLE: begin
                if (bit_q == BIT_W'(SETTLE_CYC - 1)) begin
                    state_d = S_CAPTURE;
                    bit_d   = '0;
                end else begin
                    bit_d = bit_q + BIT_W'(1);
                end
            end
            S_CAPTURE: begin
                periodic = 1'b1;
                last_bit = '0;
                next_st  = S_SHIFT;
            end
            S_SHIFT: begin
                periodic = 1'b1;
                last_bit = BIT_W'(LEN - 1);
                next_st  = S_DONE;
                // Sample in the last low cycle, just ahead of the scan clock rising edge
                if (phase_q == PH_W'(CLK_DIV - 1)) begin
                    shreg_d = LEN'({shreg_q, shift_out_data});
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (periodic) begin
            phase_d = period_end ? '0 : phase_q + PH_W'(1);
            if (period_end) begin
                if (bit_q == last_bit) begin
                    state_d = next_st;
                    bit_d   = '0;
                end else begin
                    bit_d = bit_q + BIT_W'(1);
                end
            end
        end

        if (state_d == S_DONE) begin
            resp_d = shreg_d;
        end

        hi_d       = (phase_d >= PH_W'(CLK_DIV));
        load_bits  = word_d << bit_d;
        busy_d     = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d     = (state_d == S_DONE);
        sca_clk_d  = (state_d == S_LOAD) && hi_d;
        sca_data_d = (state_d == S_LOAD) && load_bits[WORD_W-1];
        flip_clk_d = (state_d == S_FLIP) && hi_d;
        so_en_d    = (state_d == S_SHIFT);
        so_clk_d   = ((state_d == S_CAPTURE) || (state_d == S_SHIFT)) && hi_d;
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign resp             = resp_q;
    assign sca_clk          = sca_clk_q;
    assign sca_data         = sca_data_q;
    assign flip_clk         = flip_clk_q;
    assign shift_out_enable = so_en_q;
    assign shift_out_clk    = so_clk_q;

endmodule
